// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle sequencer:
//   state_t        - sequencer FSM state encoding (4 bits, codes 10-15 unused)
//   ALU_*          - alu_control encodings
//   RES_*          - result_src encodings
//   SRCB_*         - alu_src_b encodings
//   IMM_*          - imm_src encodings
//   REGSRC_*       - reg_src encodings
//   alu_decode()   - maps the data-processing cmd field onto an ALU op
// -----------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;  // registered ALU result
    localparam logic [1:0] RES_RDATA  = 2'b01;  // memory read data
    localparam logic [1:0] RES_ALU    = 2'b10;  // live ALU output (PC+4 / PC+8 / target)

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REGSRC_DP  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_MEM = 2'b10;

    // Unsupported cmd values fall back to ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            4'b0100: alu_decode = ALU_ADD;
            4'b0010: alu_decode = ALU_SUB;
            4'b0000: alu_decode = ALU_AND;
            4'b1100: alu_decode = ALU_ORR;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// -----------------------------------------------------------------------------
// mc_sequencer_if
// Bundle of the sequencer <-> datapath signals.
//   master : the sequencer (drives strobes/selects, observes instr/flags/ready)
//   slave  : the datapath/memory side (the reverse direction)
//
// Handshake: mem_ready is the only flow-control signal. An access is held
// (address select, mem_write) for as long as the sequencer sits in a memory
// state; the access completes in the cycle where mem_ready=1 is sampled on the
// rising edge of clk, and the sequencer leaves the state on that edge.
// -----------------------------------------------------------------------------
interface mc_sequencer_if;
    import mc_pkg::*;

    logic [19:0] instr;
    logic [3:0]  alu_flags;
    logic        mem_ready;
    logic        pc_write;
    logic        adr_src;
    logic        ir_write;
    logic        mem_write;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_control;
    logic [1:0]  imm_src;
    logic [1:0]  reg_src;
    logic [3:0]  state;

    modport master (
        input  instr, alu_flags, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a,
               result_src, alu_src_b, alu_control, imm_src, reg_src, state
    );

    modport slave (
        output instr, alu_flags, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a,
               result_src, alu_src_b, alu_control, imm_src, reg_src, state
    );

endinterface

// File: rtl/mc_condeval.sv
// -----------------------------------------------------------------------------
// mc_condeval
// ARM condition-code evaluation.
//   cond   [3:0] in  - instruction condition field
//   flags  [3:0] in  - stored {N,Z,C,V}
//   condex       out - 1 when the instruction is to execute; code 1111 gives 0
// -----------------------------------------------------------------------------
module mc_condeval (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        condex = 1'b0;
        case (cond)
            4'b0000: condex = z;                   // EQ
            4'b0001: condex = ~z;                  // NE
            4'b0010: condex = c;                   // CS
            4'b0011: condex = ~c;                  // CC
            4'b0100: condex = n;                   // MI
            4'b0101: condex = ~n;                  // PL
            4'b0110: condex = v;                   // VS
            4'b0111: condex = ~v;                  // VC
            4'b1000: condex = c & ~z;              // HI
            4'b1001: condex = ~c | z;              // LS
            4'b1010: condex = (n == v);            // GE
            4'b1011: condex = (n != v);            // LT
            4'b1100: condex = ~z & (n == v);       // GT
            4'b1101: condex = z | (n != v);        // LE
            4'b1110: condex = 1'b1;                // AL
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// -----------------------------------------------------------------------------
// mc_sequencer
// Moore control FSM for a multi-cycle ARM-subset processor with a unified
// memory that signals completion through mem_ready.
//
// Ports
//   clk, reset          - rising-edge clock; asynchronous active-high reset
//   instr      [19:0]   - latched IR[31:12] = {cond, op, funct, rn, rd}
//   alu_flags  [3:0]    - live ALU {N,Z,C,V}
//   mem_ready           - memory completes the current access this cycle
//   pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a - strobes/selects
//   result_src, alu_src_b, alu_control, imm_src, reg_src [1:0]  - selects
//   state      [3:0]    - current FSM state (debug)
//   retired    [31:0]   - retired-instruction count (MC_SEQUENCER_PERF_EN only)
//
// Parameter
//   RESET_STATE         - state entered on reset (default FETCH)
//
// Build option
//   MC_SEQUENCER_PERF_EN - adds the retired counter and its port.
// -----------------------------------------------------------------------------
module mc_sequencer
    import mc_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        mem_write,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_control,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [3:0]  state
`ifdef MC_SEQUENCER_PERF_EN
    ,
    output logic [31:0] retired
`endif
);

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = instr[19:16];
    assign op        = instr[15:14];
    assign funct     = instr[13:8];
    assign rd        = instr[3:0];
    assign unused_rn = ^instr[7:4];

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex;
    logic       is_addsub;

    // Strobes before reset gating
    logic pc_write_c, ir_write_c, mem_write_c, reg_write_c;

    mc_condeval u_condeval (
        .cond   (cond),
        .flags  (flags_q),
        .condex (condex)
    );

    assign is_addsub = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d     = FETCH;
        flags_d     = flags_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_b   = SRCB_REG;
        alu_control = ALU_ADD;
        imm_src     = IMM_DP;
        reg_src     = REGSRC_DP;

        case (state_q)
            FETCH: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALU;
                // IR and PC only capture on the cycle the fetch completes.
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
                state_d     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                case (op)
                    2'b01:   reg_src = REGSRC_MEM;
                    2'b10:   reg_src = REGSRC_BR;
                    default: reg_src = REGSRC_DP;
                endcase
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_MEM;
                state_d   = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWR: begin
                adr_src     = 1'b1;
                mem_write_c = condex;
                state_d     = mem_ready ? FETCH : MEMWR;
            end
            MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_c = condex;
                state_d     = FETCH;
            end
            EXECR, EXECI: begin
                alu_src_b   = (state_q == EXECI) ? SRCB_IMM : SRCB_REG;
                alu_control = alu_decode(funct[4:1]);
                // Flags follow the ALU while it is computing this instruction;
                // C/V are only meaningful for arithmetic ops.
                if (funct[0] && condex) begin
                    flags_d[3:2] = alu_flags[3:2];
                    if (is_addsub) begin
                        flags_d[1:0] = alu_flags[1:0];
                    end
                end
                state_d = ALUWB;
            end
            ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write_c = condex;
                pc_write_c  = condex && (rd == 4'd15);
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_BR;
                result_src = RES_ALU;
                pc_write_c = condex;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write strobes must be quiet for the whole reset pulse, not just after
    // the next edge, since FETCH would otherwise fire ir/pc writes on mem_ready.
    assign pc_write  = pc_write_c  & ~reset;
    assign ir_write  = ir_write_c  & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign reg_write = reg_write_c & ~reset;
    assign state     = state_q;

`ifdef MC_SEQUENCER_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic        retire;

    always_comb begin
        retire = 1'b0;
        if (state_d == FETCH) begin
            case (state_q)
                MEMWB, MEMWR, ALUWB, BRANCH: retire = 1'b1;
                default:                     retire = 1'b0;
            endcase
        end
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mc_sequencer
// Directed bench for mc_sequencer: ADD-immediate flow, fetch stall, LDR flow,
// flag-conditioned branches, undefined op, ORR to PC, reset during a store.
// Define MC_SEQUENCER_PERF_EN to also exercise the retired counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mc_sequencer;
    import mc_pkg::*;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    mc_sequencer_if bus ();

`ifdef MC_SEQUENCER_PERF_EN
    logic [31:0] retired;
`endif

    mc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
`ifdef MC_SEQUENCER_PERF_EN
        .retired     (retired),
`endif
        .instr       (bus.instr),
        .alu_flags   (bus.alu_flags),
        .mem_ready   (bus.mem_ready),
        .pc_write    (bus.pc_write),
        .adr_src     (bus.adr_src),
        .ir_write    (bus.ir_write),
        .mem_write   (bus.mem_write),
        .reg_write   (bus.reg_write),
        .alu_src_a   (bus.alu_src_a),
        .result_src  (bus.result_src),
        .alu_src_b   (bus.alu_src_b),
        .alu_control (bus.alu_control),
        .imm_src     (bus.imm_src),
        .reg_src     (bus.reg_src),
        .state       (bus.state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        reset            = 1'b1;
        bus.mem_ready    = 1'b1;
        bus.instr        = 20'hE2802;      // ADD r2,r0,#5
        bus.alu_flags    = 4'b0000;

        // Reset state: strobes quiet even with mem_ready=1 in FETCH
        repeat (2) @(posedge clk);
        #2;
        check("rst_state",    bus.state, 4'd0);
        check("rst_ir_write", bus.ir_write, 1'b0);
        check("rst_pc_write", bus.pc_write, 1'b0);
        check("rst_reg_write", bus.reg_write, 1'b0);
`ifdef MC_SEQUENCER_PERF_EN
        check("rst_retired", retired, 32'd0);
`endif
        reset = 1'b0;
        #1;

        // ADD immediate: FETCH -> DECODE -> EXECI -> ALUWB -> FETCH
        check("add_fetch_state", bus.state, 4'd0);
        check("add_fetch_ir",    bus.ir_write, 1'b1);
        check("add_fetch_srcb",  bus.alu_src_b, 2'b10);
        check("add_fetch_res",   bus.result_src, 2'b10);
        tick();
        check("add_dec_state", bus.state, 4'd1);
        check("add_dec_regwr", bus.reg_write, 1'b0);
        check("add_dec_regsrc", bus.reg_src, 2'b00);
        tick();
        check("add_execi_state", bus.state, 4'd7);
        check("add_execi_srcb",  bus.alu_src_b, 2'b01);
        check("add_execi_aluc",  bus.alu_control, 2'b00);
        check("add_execi_regwr", bus.reg_write, 1'b0);
        tick();
        check("add_aluwb_state", bus.state, 4'd8);
        check("add_aluwb_regwr", bus.reg_write, 1'b1);
        check("add_aluwb_pcwr",  bus.pc_write, 1'b0);
        tick();
        check("add_back_fetch", bus.state, 4'd0);

        // Fetch stall: 3 cycles with mem_ready=0, completes on the 4th
        bus.mem_ready = 1'b0;
        bus.instr     = 20'hE5912;         // LDR r2,[r1]
        #1;
        check("stall1_state", bus.state, 4'd0);
        check("stall1_ir",    bus.ir_write, 1'b0);
        tick();
        check("stall2_state", bus.state, 4'd0);
        check("stall2_ir",    bus.ir_write, 1'b0);
        tick();
        check("stall3_state", bus.state, 4'd0);
        check("stall3_ir",    bus.ir_write, 1'b0);
        tick();
        bus.mem_ready = 1'b1;
        #1;
        check("stall4_ir", bus.ir_write, 1'b1);
        check("stall4_pc", bus.pc_write, 1'b1);

        // LDR: DECODE -> MEMADR -> MEMRD (one wait) -> MEMWB -> FETCH
        tick();
        check("ldr_dec_regsrc", bus.reg_src, 2'b10);
        tick();
        check("ldr_memadr_state", bus.state, 4'd2);
        check("ldr_memadr_imm",   bus.imm_src, 2'b01);
        check("ldr_memadr_srcb",  bus.alu_src_b, 2'b01);
        bus.mem_ready = 1'b0;
        tick();
        check("ldr_memrd_state", bus.state, 4'd3);
        check("ldr_memrd_adr",   bus.adr_src, 1'b1);
        tick();
        check("ldr_memrd_wait", bus.state, 4'd3);
        bus.mem_ready = 1'b1;
        tick();
        check("ldr_memwb_state", bus.state, 4'd4);
        check("ldr_memwb_res",   bus.result_src, 2'b01);
        check("ldr_memwb_regwr", bus.reg_write, 1'b1);
        tick();
        check("ldr_back_fetch", bus.state, 4'd0);

        // SUBS r1,r1,#1 producing C=1, Z=0
        bus.instr = 20'hE2511;
        tick();
        tick();
        check("subs_execi_state", bus.state, 4'd7);
        check("subs_execi_aluc",  bus.alu_control, 2'b01);
        bus.alu_flags = 4'b0010;
        tick();
        bus.alu_flags = 4'b0000;
        check("subs_aluwb_state", bus.state, 4'd8);
        tick();

        // BEQ with Z=0: BRANCH reached, not taken
        bus.instr = 20'h0A000;
        tick();
        check("beq_dec_regsrc", bus.reg_src, 2'b01);
        tick();
        check("beq_branch_state", bus.state, 4'd9);
        check("beq_branch_pcwr",  bus.pc_write, 1'b0);
        check("beq_branch_imm",   bus.imm_src, 2'b10);
        check("beq_branch_res",   bus.result_src, 2'b10);
        tick();
        check("beq_back_fetch", bus.state, 4'd0);
`ifdef MC_SEQUENCER_PERF_EN
        check("retired_after4", retired, 32'd4);
`endif

        // BNE with Z=0: taken
        bus.instr = 20'h1A000;
        tick();
        tick();
        check("bne_branch_pcwr", bus.pc_write, 1'b1);
        tick();

        // op=11: DECODE falls straight back to FETCH, not retired
        bus.instr = 20'hEC000;
        tick();
        check("op11_dec_regwr", bus.reg_write, 1'b0);
        tick();
        check("op11_back_fetch", bus.state, 4'd0);
`ifdef MC_SEQUENCER_PERF_EN
        check("retired_after_op11", retired, 32'd5);
`endif

        // STR stalled in MEMWR, then reset mid-access
        bus.instr = 20'hE5812;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        check("str_memwr_state", bus.state, 4'd5);
        check("str_memwr_mw",    bus.mem_write, 1'b1);
        check("str_memwr_adr",   bus.adr_src, 1'b1);
        tick();
        check("str_memwr_hold", bus.mem_write, 1'b1);
        reset = 1'b1;
        #1;
        check("str_rst_mw",    bus.mem_write, 1'b0);
        check("str_rst_state", bus.state, 4'd0);
`ifdef MC_SEQUENCER_PERF_EN
        check("str_rst_retired", retired, 32'd0);
`endif
        bus.instr     = 20'hE180F;         // ORR pc,r0,r0
        bus.mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_state", bus.state, 4'd0);

        // ORR register form writing r15: pc_write in ALUWB
        tick();
        tick();
        check("orr_execr_state", bus.state, 4'd6);
        check("orr_execr_srcb",  bus.alu_src_b, 2'b00);
        check("orr_execr_aluc",  bus.alu_control, 2'b11);
        check("orr_execr_srca",  bus.alu_src_a, 1'b0);
        tick();
        check("orr_aluwb_regwr", bus.reg_write, 1'b1);
        check("orr_aluwb_pcwr",  bus.pc_write, 1'b1);
        tick();
        check("orr_back_fetch", bus.state, 4'd0);
`ifdef MC_SEQUENCER_PERF_EN
        check("retired_after_orr", retired, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
